// File: rtl/soustraction16_serie.sv
// Bit-serial unsigned subtractor: {r1,s} = e1 - e2 - r0, LSB first, one bit per clock.
// Three-state control (IDLE/RUN/DONE); s and r1 update only on entry to DONE.
module soustraction16_serie #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] e1,
    input  logic [N-1:0] e2,
    input  logic         r0,
    output logic [N-1:0] s,
    output logic         r1,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_q, b_q;
    logic [N-2:0]   res_q;      // bits 0..N-2; the final bit goes straight into s
    logic           bor_q;
    logic [CW-1:0]  cnt_q;
    logic           last, d_bit, bor_nxt;

    assign last    = (cnt_q == CW'(N - 1));
    assign d_bit   = a_q[0] ^ b_q[0] ^ bor_q;
    assign bor_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            bor_q <= 1'b0;
            cnt_q <= '0;
            s     <= '0;
            r1    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state_nxt == DONE);
            case (state)
                IDLE: if (start) begin
                    a_q   <= e1;
                    b_q   <= e2;
                    bor_q <= r0;
                    cnt_q <= '0;
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    bor_q <= bor_nxt;
                    res_q <= {d_bit, res_q[N-2:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        s  <= {d_bit, res_q};
                        r1 <= bor_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/soustraction16_serie.md
SOUSTRACTION16_SERIE -- requirements
Module: soustraction16_serie

Interface
REQ-001: Parameter N, default 16, operand width in bits; only N=16 is required to be verified.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005: e1  input  16  minuend, unsigned.
REQ-006: e2  input  16  subtrahend, unsigned.
REQ-007: r0  input  1  borrow-in.
REQ-008: s  output  16  difference, registered.
REQ-009: r1  output  1  borrow-out, registered.
REQ-010: busy  output  1  high while an operation is in progress.
REQ-011: done  output  1  one-cycle completion pulse, registered.

Function
REQ-012: The result SHALL satisfy {r1,s} = e1 - e2 - r0, taken modulo 2^17: s = (e1 - e2 - r0) mod 2^16, and r1 = 1 exactly when e1 < e2 + r0, compared as unsigned values.
REQ-013: The computation SHALL be bit-serial, LSB first, with one bit per clock, using a 1-bit borrow flop and a 5-bit bit counter.
REQ-014: The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015: IDLE -> RUN when start=1 on a clk edge; on that edge e1, e2 and r0 are latched into internal registers and the counter is cleared.
REQ-016: In RUN, each edge computes one difference bit and one new borrow from the latched bits and the borrow flop, shifts the bit into the internal result register, and increments the counter.
REQ-017: RUN -> DONE on the edge that processes bit 15; on that same edge, s and r1 are loaded from the internal result and the final borrow.
REQ-018: DONE -> IDLE unconditionally on the next edge.
REQ-019: Latency: if start is sampled at edge k, done=1 in the cycle following edge k+16, and done falls after edge k+17.
REQ-020: done=1 only in DONE, for exactly one cycle per accepted start.
REQ-021: busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-022: start SHALL be accepted only in IDLE; start in RUN or DONE is ignored and queues nothing.
REQ-023: start held high continuously yields back-to-back operations, one every 18 cycles.
REQ-024: e1, e2 and r0 may change after the accepting edge without affecting the result in progress.
REQ-025: s and r1 hold their last result through IDLE and the next RUN, and change only on entry to DONE.
REQ-026: Wrap-around: an underflow produces the modulo-2^16 difference with r1=1, and no other flag is raised.

Reset
REQ-027: rst_n=0 SHALL immediately force state=IDLE and s=0, r1=0, busy=0, done=0, independent of clk.
REQ-028: rst_n=0 SHALL also clear the counter, the borrow flop and all internal registers.
REQ-029: Reset asserted mid-RUN SHALL abort the operation; no done pulse follows, and the outputs stay at 0.
REQ-030: After rst_n deasserts, the first start is accepted normally.

Verification
REQ-031: e1=0x1234, e2=0x0234, r0=0, start pulse -> done 17 cycles later, s=0x1000, r1=0.
REQ-032: e1=0x0000, e2=0x0001, r0=0 -> s=0xFFFF, r1=1.
REQ-033: e1=0xFFFF, e2=0xFFFF, r0=1 -> s=0xFFFF, r1=1; then e1=0x8000, e2=0x0000, r0=1 -> s=0x7FFF, r1=0.
REQ-034: start re-pulsed with new operands during RUN -> ignored; the first result is reported, a single done pulse occurs, and s is unchanged before DONE.
REQ-035: rst_n pulsed low during cycle 8 of RUN -> s=0, r1=0, busy=0 at once, and no done pulse; a subsequent start of 5-3 gives s=0x0002, r1=0.
REQ-036: 1000 random {e1,e2,r0} with random start spacing -> every done pulse matches the 17-bit reference model {r1,s} = e1 - e2 - r0, and busy/done timing matches REQ-019 to REQ-021.
